mem_line_responder: RTL and testbench

- Main-memory model at the far end of the cache line-fill/writeback interface (mem_req/mem_write toward memory, mem_res back toward the cache).
- Accepts line-read requests into a small pending queue and services them one at a time after a fixed latency.
- Returns each line with its address as a one-cycle response pulse.
- Absorbs full-line writebacks in a single cycle.

---
 rtl/mem_line_responder_pkg.sv | 23 ++
 rtl/mem_line_responder_if.sv | 32 +++
 rtl/mem_line_responder_line_req_fifo.sv | 86 ++++++++
 rtl/mem_line_responder.sv | 155 +++++++++++++++
 tb/tb_mem_line_responder.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_line_responder_pkg.sv
// Shared definitions for the main-memory line responder.
//   MLR_WORD_SIZE   : default address/word width
//   MLR_LINE_SIZE   : default cache line width in bits
//   MLR_MEM_LATENCY : default cycles from start of service to response
//   state_t         : service FSM states
//   line_offset_bits: byte-offset width inside a line of the given bit width
package mem_line_responder_pkg;

   localparam int MLR_WORD_SIZE   = 32;
   localparam int MLR_LINE_SIZE   = 128;
   localparam int MLR_OFFSET_BITS = $clog2(MLR_LINE_SIZE / 8);
   localparam int MLR_MEM_LATENCY = 5;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   function automatic int line_offset_bits(input int line_size);
      return $clog2(line_size / 8);
   endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// Line-fill / writeback bus between a cache (master) and main memory (slave).
//   mem_req/mem_req_addr                      : line-read request
//   mem_write/mem_write_addr/mem_write_data   : full-line writeback
//   mem_res/mem_res_addr/mem_res_data         : one-cycle response pulse
//   busy/overflow                             : memory-side status
interface mem_line_responder_if
   import mem_line_responder_pkg::*;
#(
   parameter int WORD_SIZE = MLR_WORD_SIZE,
   parameter int LINE_SIZE = MLR_LINE_SIZE
);
   logic                 mem_req;
   logic [WORD_SIZE-1:0] mem_req_addr;
   logic                 mem_write;
   logic [WORD_SIZE-1:0] mem_write_addr;
   logic [LINE_SIZE-1:0] mem_write_data;
   logic                 mem_res;
   logic [WORD_SIZE-1:0] mem_res_addr;
   logic [LINE_SIZE-1:0] mem_res_data;
   logic                 busy;
   logic                 overflow;

   modport master (
      output mem_req, mem_req_addr, mem_write, mem_write_addr, mem_write_data,
      input  mem_res, mem_res_addr, mem_res_data, busy, overflow
   );

   modport slave (
      input  mem_req, mem_req_addr, mem_write, mem_write_addr, mem_write_data,
      output mem_res, mem_res_addr, mem_res_data, busy, overflow
   );
endinterface

// File: rtl/mem_line_responder_line_req_fifo.sv
// line_req_fifo: FIFO of pending line addresses with a parallel "contains"
// match used to coalesce repeated requests for a line already waiting.
//   clk, rst             : clock, asynchronous active-low reset
//   push_i/push_addr_i   : enqueue a line address
//   pop_i                : dequeue the head (only when non-empty)
//   match_addr_i         : address compared against every valid entry
//   head_o               : oldest entry (the one in service)
//   full_o/empty_o       : occupancy flags
//   count_o              : number of valid entries
//   contains_o           : match_addr_i equals some valid entry
// DEPTH must be a power of two, at least 2.
module line_req_fifo #(
   parameter int ADDR_W = 28,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [ADDR_W-1:0]          push_addr_i,
   input  logic [ADDR_W-1:0]          match_addr_i,
   output logic [ADDR_W-1:0]          head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       contains_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] entry_q [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [DEPTH-1:0]  match;

   // Address storage needs no reset: validity is tracked separately.
   always_ff @(posedge clk) begin
      if (push_i) begin
         entry_q[wr_ptr_q] <= push_addr_i;
      end
   end

   // Push wins over pop on the same slot: that only happens when a full
   // queue pops and refills in one edge, leaving the slot occupied.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (push_i && (wr_ptr_q == PTR_W'(i))) begin
               valid_q[i] <= 1'b1;
            end else if (pop_i && (rd_ptr_q == PTR_W'(i))) begin
               valid_q[i] <= 1'b0;
            end
         end
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         assign match[gi] = valid_q[gi] && (entry_q[gi] == match_addr_i);
      end
   endgenerate

   assign contains_o = |match;
   assign head_o     = entry_q[rd_ptr_q];
   assign full_o     = (count_q == CNT_W'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
endmodule

// File: rtl/mem_line_responder.sv
// mem_line_responder: main-memory model behind a cache line-fill/writeback
// bus. Line reads are queued (duplicates coalesced), served one at a time
// after MEM_LATENCY cycles, and answered with a one-cycle response pulse.
// Writebacks land in the backing array in a single cycle.
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : slave side of mem_line_responder_if (requests, writebacks,
//         response, busy, sticky overflow)
module mem_line_responder
   import mem_line_responder_pkg::*;
#(
   parameter int WORD_SIZE   = MLR_WORD_SIZE,
   parameter int LINE_SIZE   = MLR_LINE_SIZE,
   parameter int MEM_LINES   = 256,
   parameter int MEM_LATENCY = MLR_MEM_LATENCY,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_line_responder_if.slave  bus
);
   localparam int OFFSET_BITS = line_offset_bits(LINE_SIZE);
   localparam int LA_W        = WORD_SIZE - OFFSET_BITS;
   localparam int IDX_W       = $clog2(MEM_LINES);
   localparam int CNT_W       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int QC_W        = $clog2(QUEUE_DEPTH + 1);

   // Backing store; contents survive reset.
   logic [LINE_SIZE-1:0] mem_q [MEM_LINES];

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 res_q, res_d;
   logic [WORD_SIZE-1:0] res_addr_q, res_addr_d;
   logic [LINE_SIZE-1:0] res_data_q, res_data_d;
   logic                 overflow_q, overflow_d;

   logic [LA_W-1:0]      req_line;
   logic [LA_W-1:0]      wr_line;
   logic [LA_W-1:0]      head_line;
   logic [LINE_SIZE-1:0] rd_data;
   logic                 q_full, q_empty, q_contains;
   logic [QC_W-1:0]      q_count;
   logic                 pop, push, can_push;

   assign req_line = bus.mem_req_addr[WORD_SIZE-1:OFFSET_BITS];
   assign wr_line  = bus.mem_write_addr[WORD_SIZE-1:OFFSET_BITS];

   // ---------------- backing array ----------------
   always_ff @(posedge clk) begin
      if (bus.mem_write) begin
         mem_q[wr_line[IDX_W-1:0]] <= bus.mem_write_data;
      end
   end

   // Combinational read: a write on the response edge is not yet visible,
   // giving read-before-write on that edge.
   assign rd_data = mem_q[head_line[IDX_W-1:0]];

   // ---------------- request queue ----------------
   assign pop      = (state_q == ST_SERVE) && (cnt_q == '0);
   // A full queue still accepts when the head leaves on the same edge.
   assign can_push = !q_full || pop;
   assign push     = bus.mem_req && !q_contains && can_push;

   line_req_fifo #(
      .ADDR_W (LA_W),
      .DEPTH  (QUEUE_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_i       (push),
      .pop_i        (pop),
      .push_addr_i  (req_line),
      .match_addr_i (req_line),
      .head_o       (head_line),
      .full_o       (q_full),
      .empty_o      (q_empty),
      .count_o      (q_count),
      .contains_o   (q_contains)
   );

   // ---------------- service FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         res_q      <= 1'b0;
         res_addr_q <= '0;
         res_data_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         res_q      <= res_d;
         res_addr_q <= res_addr_d;
         res_data_q <= res_data_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      res_d      = 1'b0;
      res_addr_d = res_addr_q;
      res_data_d = res_data_q;
      overflow_d = overflow_q;

      if (bus.mem_req && !q_contains && !can_push) begin
         overflow_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (!q_empty) begin
               state_d = ST_SERVE;
               cnt_d   = CNT_W'(MEM_LATENCY - 1);
            end
         end
         ST_SERVE: begin
            if (cnt_q == '0) begin
               res_d      = 1'b1;
               res_addr_d = {head_line, {OFFSET_BITS{1'b0}}};
               res_data_d = rd_data;
               // Queue is non-empty after this edge if another entry waits
               // behind the head or a new one arrives now.
               if ((q_count > QC_W'(1)) || push) begin
                  cnt_d = CNT_W'(MEM_LATENCY - 1);
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.mem_res      = res_q;
   assign bus.mem_res_addr = res_addr_q;
   assign bus.mem_res_data = res_data_q;
   assign bus.busy         = !q_empty;
   assign bus.overflow     = overflow_q;

   // Offset bits are ignored by design; upper line bits above the array
   // index alias onto the same array line.
   logic unused_bits;
   assign unused_bits = ^{bus.mem_req_addr[OFFSET_BITS-1:0],
                          bus.mem_write_addr[OFFSET_BITS-1:0],
                          wr_line[LA_W-1:IDX_W]};
endmodule

// File: tb/tb_mem_line_responder.sv
module tb_mem_line_responder;
   import mem_line_responder_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   pulses = 0;

   typedef struct {
      logic [31:0]  addr;
      logic [127:0] data;
      int           cyc;
   } exp_t;
   exp_t exp_q[$];

   mem_line_responder_if #(.WORD_SIZE(32), .LINE_SIZE(128)) bus ();

   mem_line_responder #(
      .WORD_SIZE   (32),
      .LINE_SIZE   (128),
      .MEM_LINES   (256),
      .MEM_LATENCY (5),
      .QUEUE_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] line_of(input logic [31:0] a);
      return {a ^ 32'hA5A5_0001, a ^ 32'h5A5A_0002, ~a, a};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s: %h (cycle %0d)", name, act, cyc);
      end
   endtask

   task automatic expect_res(input logic [31:0] a, input logic [127:0] d, input int c);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   // Monitor / scoreboard: compares every response pulse with the queue.
   always @(negedge clk) begin
      if (rst && bus.mem_res) begin
         pulses++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_res: got addr %h data %h at cycle %0d, expected none",
                     bus.mem_res_addr, bus.mem_res_data, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("res_addr", {96'b0, bus.mem_res_addr}, {96'b0, e.addr});
            chk("res_data", bus.mem_res_data, e.data);
            chk("res_cycle", 128'(cyc), 128'(e.cyc));
         end
      end
   end

   task automatic wr(input logic [31:0] a, input logic [127:0] d);
      @(negedge clk);
      bus.mem_write      = 1'b1;
      bus.mem_write_addr = a;
      bus.mem_write_data = d;
      @(negedge clk);
      bus.mem_write      = 1'b0;
   endtask

   // Drives a request for the next edge and returns that edge number.
   task automatic issue(input logic [31:0] a, output int edge_no);
      @(negedge clk);
      bus.mem_req      = 1'b1;
      bus.mem_req_addr = a;
      edge_no          = cyc + 1;
   endtask

   task automatic drop_req();
      @(negedge clk);
      bus.mem_req = 1'b0;
   endtask

   localparam logic [127:0] T1_DATA = 128'h11112222333344445555666677778888;
   localparam logic [127:0] DATA_A  = 128'hAAAA0000AAAA0000AAAA0000AAAA0000;
   localparam logic [127:0] DATA_B  = 128'hBBBB1111BBBB1111BBBB1111BBBB1111;
   localparam logic [127:0] DATA_C  = 128'hCCCC2222CCCC2222CCCC2222CCCC2222;
   localparam logic [127:0] DATA_E  = 128'hEEEE3333EEEE3333EEEE3333EEEE3333;

   initial begin
      int e, e2, p0;
      bit got;
      logic [31:0] init_addrs [9] = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h50,
                                      32'h60, 32'h70, 32'h80, 32'h90};
      bus.mem_req        = 1'b0;
      bus.mem_req_addr   = '0;
      bus.mem_write      = 1'b0;
      bus.mem_write_addr = '0;
      bus.mem_write_data = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_mem_res", {127'b0, bus.mem_res}, 128'd0);
      chk("rst_res_addr", {96'b0, bus.mem_res_addr}, 128'd0);
      chk("rst_res_data", bus.mem_res_data, 128'd0);
      chk("rst_busy", {127'b0, bus.busy}, 128'd0);
      chk("rst_overflow", {127'b0, bus.overflow}, 128'd0);
      rst = 1'b1;

      // Preload lines used below
      foreach (init_addrs[i]) wr(init_addrs[i], line_of(init_addrs[i]));
      wr(32'h40, T1_DATA);
      wr(32'hC0, DATA_A);
      wr(32'hD0, DATA_C);

      // 1: single request, offset ignored, latency 6 edges after acceptance
      issue(32'h44, e);
      expect_res(32'h40, T1_DATA, e + 6);
      drop_req();
      repeat (5) @(negedge clk);
      chk("t1_no_early_res", {127'b0, bus.mem_res}, 128'd0);
      chk("t1_busy_waiting", {127'b0, bus.busy}, 128'd1);
      repeat (2) @(negedge clk);
      chk("t1_pulse_one_cycle", {127'b0, bus.mem_res}, 128'd0);
      chk("t1_hold_addr", {96'b0, bus.mem_res_addr}, 128'h40);
      chk("t1_busy_done", {127'b0, bus.busy}, 128'd0);

      // 2: level-held request coalesces to one response
      issue(32'h80, e);
      expect_res(32'h80, line_of(32'h80), e + 6);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #2;
         if (bus.mem_res) begin
            got = 1'b1;
            break;
         end
      end
      bus.mem_req = 1'b0;
      chk("t2_res_seen", {127'b0, got}, 128'd1);
      @(negedge clk);
      #2;
      chk("t2_busy_after", {127'b0, bus.busy}, 128'd0);
      repeat (10) @(negedge clk);

      // 3: three consecutive requests served back-to-back, 5 cycles apart
      issue(32'h00, e);
      issue(32'h10, e2);
      issue(32'h20, e2);
      drop_req();
      expect_res(32'h00, line_of(32'h00), e + 6);
      expect_res(32'h10, line_of(32'h10), e + 11);
      expect_res(32'h20, line_of(32'h20), e + 16);
      repeat (22) @(negedge clk);
      chk("t3_drained", {127'b0, bus.busy}, 128'd0);

      // 4a: full queue plus pop on the same edge still accepts
      issue(32'h00, e);
      issue(32'h10, e2);
      issue(32'h20, e2);
      issue(32'h30, e2);
      drop_req();
      @(negedge clk);
      issue(32'h50, e2);
      drop_req();
      chk("t4a_push_on_pop_edge", 128'(e2), 128'(e + 6));
      expect_res(32'h00, line_of(32'h00), e + 6);
      expect_res(32'h10, line_of(32'h10), e + 11);
      expect_res(32'h20, line_of(32'h20), e + 16);
      expect_res(32'h30, line_of(32'h30), e + 21);
      expect_res(32'h50, line_of(32'h50), e + 26);
      repeat (28) @(negedge clk);
      chk("t4a_no_overflow", {127'b0, bus.overflow}, 128'd0);

      // 4: five distinct requests, fifth dropped, overflow sticky
      p0 = pulses;
      issue(32'h00, e);
      issue(32'h10, e2);
      issue(32'h20, e2);
      issue(32'h30, e2);
      @(negedge clk);
      #2;
      chk("t4_ovf_before", {127'b0, bus.overflow}, 128'd0);
      bus.mem_req_addr = 32'h50;
      @(negedge clk);
      bus.mem_req = 1'b0;
      #2;
      chk("t4_ovf_set", {127'b0, bus.overflow}, 128'd1);
      expect_res(32'h00, line_of(32'h00), e + 6);
      expect_res(32'h10, line_of(32'h10), e + 11);
      expect_res(32'h20, line_of(32'h20), e + 16);
      expect_res(32'h30, line_of(32'h30), e + 21);
      repeat (25) @(negedge clk);
      #2;
      chk("t4_pulse_count", 128'(pulses - p0), 128'd4);
      chk("t4_ovf_sticky", {127'b0, bus.overflow}, 128'd1);

      // 5: write to a pending line before response is visible
      issue(32'hC0, e);
      expect_res(32'hC0, DATA_B, e + 6);
      drop_req();
      @(negedge clk);
      bus.mem_write      = 1'b1;
      bus.mem_write_addr = 32'hC0;
      bus.mem_write_data = DATA_B;
      @(negedge clk);
      bus.mem_write      = 1'b0;
      repeat (8) @(negedge clk);

      // 5b: write on the response edge itself returns the old line
      issue(32'hD0, e);
      expect_res(32'hD0, DATA_C, e + 6);
      drop_req();
      repeat (5) @(negedge clk);
      bus.mem_write      = 1'b1;
      bus.mem_write_addr = 32'hD0;
      bus.mem_write_data = DATA_E;
      @(negedge clk);
      bus.mem_write      = 1'b0;
      repeat (3) @(negedge clk);
      issue(32'hD8, e);
      expect_res(32'hD0, DATA_E, e + 6);
      drop_req();
      repeat (8) @(negedge clk);

      // 6: asynchronous reset while a response is up and another is queued
      issue(32'h60, e);
      issue(32'h70, e2);
      expect_res(32'h60, line_of(32'h60), e + 6);
      drop_req();
      repeat (5) @(negedge clk);
      #2;
      chk("t6_res_before_rst", {127'b0, bus.mem_res}, 128'd1);
      chk("t6_busy_before_rst", {127'b0, bus.busy}, 128'd1);
      rst = 1'b0;
      #1;
      chk("t6_res_async_clr", {127'b0, bus.mem_res}, 128'd0);
      chk("t6_busy_async_clr", {127'b0, bus.busy}, 128'd0);
      chk("t6_ovf_async_clr", {127'b0, bus.overflow}, 128'd0);
      p0 = pulses;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      chk("t6_no_res_after_rst", 128'(pulses - p0), 128'd0);
      issue(32'h90, e);
      expect_res(32'h90, line_of(32'h90), e + 6);
      drop_req();
      repeat (10) @(negedge clk);

      chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
